// File: rtl/adventure_pkg.sv
// rtl/adventure_pkg.sv - shared state/direction types and button decode for the grid adventure
package adventure_pkg;

  typedef enum logic [1:0] {
    EXPLORE = 2'd0,
    DRAGON  = 2'd1,
    WIN     = 2'd2,
    DEAD    = 2'd3
  } adv_state_t;

  typedef enum logic [2:0] {
    N    = 3'd0,
    S    = 3'd1,
    E    = 3'd2,
    W    = 3'd3,
    NONE = 3'd4
  } adv_dir_t;

  // Chords and idle both decode to NONE so they can never move the player.
  function automatic adv_dir_t onehot_dir(input logic n, input logic s,
                                          input logic e, input logic w);
    adv_dir_t d;
    case ({n, s, e, w})
      4'b1000: d = N;
      4'b0100: d = S;
      4'b0010: d = E;
      4'b0001: d = W;
      default: d = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/adv_pos_ctr.sv
// rtl/adv_pos_ctr.sv - row/col position register with grid-edge blocking
module adv_pos_ctr
  import adventure_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int START_ROW = 0,
  parameter int START_COL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  adv_dir_t                dir,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    moved,
  output logic [$clog2(ROWS)-1:0] next_row,
  output logic [$clog2(COLS)-1:0] next_col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [CW-1:0] COL_START = CW'(START_COL);

  // Destination is computed combinationally so the top can judge the
  // target room on the same edge the position updates.
  always_comb begin
    next_row = row;
    next_col = col;
    moved    = 1'b0;
    if (en) begin
      case (dir)
        N: if (row != '0) begin
          next_row = row - 1'b1;
          moved    = 1'b1;
        end
        S: if (row != ROW_LAST) begin
          next_row = row + 1'b1;
          moved    = 1'b1;
        end
        W: if (col != '0) begin
          next_col = col - 1'b1;
          moved    = 1'b1;
        end
        E: if (col != COL_LAST) begin
          next_col = col + 1'b1;
          moved    = 1'b1;
        end
        default: moved = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= ROW_START;
      col <= COL_START;
    end else if (moved) begin
      row <= next_row;
      col <= next_col;
    end
  end

endmodule

// File: rtl/adventure_grid_fsm.sv
// rtl/adventure_grid_fsm.sv - grid room adventure FSM; optional move budget via ADV_MOVE_LIMIT_EN
module adventure_grid_fsm
  import adventure_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 0,
  parameter int SWORD_ROW  = 3,
  parameter int SWORD_COL  = 0,
  parameter int DRAGON_ROW = 3,
  parameter int DRAGON_COL = 3,
  parameter int STEP_W     = 8,
  parameter int MAX_MOVES  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    n,
  input  logic                    s,
  input  logic                    e,
  input  logic                    w,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    sword,
  output logic                    dragon,
  output logic                    win,
  output logic                    dead,
  output logic [STEP_W-1:0]       step_count
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] SWORD_R  = RW'(SWORD_ROW);
  localparam logic [CW-1:0] SWORD_C  = CW'(SWORD_COL);
  localparam logic [RW-1:0] DRAGON_R = RW'(DRAGON_ROW);
  localparam logic [CW-1:0] DRAGON_C = CW'(DRAGON_COL);

  generate
    if (ROWS < 2 || COLS < 2) begin : g_bad_grid
      $error("adventure_grid_fsm: grid must be at least 2x2");
    end
    if (MAX_MOVES >= (2 ** STEP_W)) begin : g_bad_budget
      $error("adventure_grid_fsm: MAX_MOVES does not fit in STEP_W");
    end
    if ((DRAGON_ROW == START_ROW && DRAGON_COL == START_COL) ||
        (SWORD_ROW == START_ROW && SWORD_COL == START_COL) ||
        (SWORD_ROW == DRAGON_ROW && SWORD_COL == DRAGON_COL)) begin : g_bad_rooms
      $error("adventure_grid_fsm: start, sword and dragon rooms must be distinct");
    end
  endgenerate

  adv_state_t       state;
  adv_dir_t         dir;
  logic             moved;
  logic [RW-1:0]    next_row;
  logic [CW-1:0]    next_col;
  logic             to_sword;
  logic             to_dragon;
  logic             limit_hit;
  logic [STEP_W-1:0] step_next;

  assign dir = onehot_dir(n, s, e, w);

  adv_pos_ctr #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .START_ROW (START_ROW),
    .START_COL (START_COL)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .en       (state == EXPLORE),
    .dir      (dir),
    .row      (row),
    .col      (col),
    .moved    (moved),
    .next_row (next_row),
    .next_col (next_col)
  );

  assign to_sword  = (next_row == SWORD_R) && (next_col == SWORD_C);
  assign to_dragon = (next_row == DRAGON_R) && (next_col == DRAGON_C);
  assign step_next = (step_count == '1) ? step_count : step_count + 1'b1;

`ifdef ADV_MOVE_LIMIT_EN
  localparam logic [STEP_W-1:0] MOVE_CAP = STEP_W'(MAX_MOVES);
  assign limit_hit = (step_next == MOVE_CAP);
`else
  assign limit_hit = 1'b0;
`endif

  // Position lives in u_pos; it only advances while EXPLORE enables it,
  // so WIN/DEAD/DRAGON freeze everything here by simply not updating.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EXPLORE;
      sword      <= 1'b0;
      step_count <= '0;
    end else begin
      case (state)
        EXPLORE: begin
          if (moved) begin
            step_count <= step_next;
            if (to_sword) sword <= 1'b1;
            if (to_dragon)      state <= DRAGON;
            else if (limit_hit) state <= DEAD;
          end
        end
        DRAGON:  state <= sword ? WIN : DEAD;
        WIN:     state <= WIN;
        DEAD:    state <= DEAD;
        default: state <= EXPLORE;
      endcase
    end
  end

  assign dragon = (state == DRAGON);
  assign win    = (state == WIN);
  assign dead   = (state == DEAD);

endmodule

// File: tb/tb_adventure_grid_fsm.sv
// tb/tb_adventure_grid_fsm.sv - random and directed check of adventure_grid_fsm against a room-walk model
module tb_adventure_grid_fsm;

  localparam int ROWS = 4, COLS = 4;
  localparam int SWR = 3, SWC = 0, DRR = 3, DRC = 3;
  localparam int STEP_W = 8, MAX_MOVES = 20;
  localparam int STEP_MAX = (1 << STEP_W) - 1;
`ifdef ADV_MOVE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, n, s, e, w;
  logic [1:0] row, col;
  logic sword, dragon, win, dead;
  logic [STEP_W-1:0] step_count;

  int total = 0;
  int bad = 0;

  // model: plain integers for the room, the sword, the move count and the outcome
  int m_r, m_c, m_steps;
  bit m_sword, m_meeting, m_won, m_lost;

  adventure_grid_fsm #(
    .ROWS(ROWS), .COLS(COLS), .START_ROW(0), .START_COL(0),
    .SWORD_ROW(SWR), .SWORD_COL(SWC), .DRAGON_ROW(DRR), .DRAGON_COL(DRC),
    .STEP_W(STEP_W), .MAX_MOVES(MAX_MOVES)
  ) dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .row(row), .col(col), .sword(sword), .dragon(dragon),
    .win(win), .dead(dead), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit bn, input bit bs, input bit be, input bit bw);
    int nr, nc;
    if (rst) begin
      m_r = 0; m_c = 0; m_steps = 0;
      m_sword = 0; m_meeting = 0; m_won = 0; m_lost = 0;
    end else if (m_meeting) begin
      m_meeting = 0;
      if (m_sword) m_won = 1; else m_lost = 1;
    end else if (!m_won && !m_lost) begin
      if (int'(bn) + int'(bs) + int'(be) + int'(bw) == 1) begin
        nr = m_r + int'(bs) - int'(bn);
        nc = m_c + int'(be) - int'(bw);
        if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
          m_r = nr; m_c = nc;
          if (m_steps < STEP_MAX) m_steps++;
          if (m_r == SWR && m_c == SWC) m_sword = 1;
          if (m_r == DRR && m_c == DRC) m_meeting = 1;
          else if (LIMIT && m_steps == MAX_MOVES) m_lost = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("row", int'(row), m_r);
    chk("col", int'(col), m_c);
    chk("sword", int'(sword), int'(m_sword));
    chk("dragon", int'(dragon), int'(m_meeting));
    chk("win", int'(win), int'(m_won));
    chk("dead", int'(dead), int'(m_lost));
    chk("step_count", int'(step_count), m_steps);
  endtask

  task automatic cyc(input bit rst, input bit bn, input bit bs, input bit be, input bit bw);
    @(negedge clk);
    reset = rst; n = bn; s = bs; e = be; w = bw;
    @(posedge clk);
    model_step(rst, bn, bs, be, bw);
    #1;
    check_all();
  endtask

  task automatic go(input byte d);
    case (d)
      "n": cyc(0, 1, 0, 0, 0);
      "s": cyc(0, 0, 1, 0, 0);
      "e": cyc(0, 0, 0, 1, 0);
      "w": cyc(0, 0, 0, 0, 1);
      default: cyc(0, 0, 0, 0, 0);
    endcase
  endtask

  initial begin
    reset = 1'b1; n = 0; s = 0; e = 0; w = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) go("-");
    chk("reset_idle_row", int'(row), 0);
    chk("reset_idle_steps", int'(step_count), 0);

    // blocked edges and chords
    go("n"); go("w");
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1);
    chk("blocked_steps", int'(step_count), 0);

    // sword path to the dragon: win
    go("s"); go("s"); go("s");
    chk("sword_at_3_0", int'(sword), 1);
    go("e"); go("e"); go("e");
    chk("dragon_pulse", int'(dragon), 1);
    go("n");
    chk("win_sticky", int'(win), 1);
    go("w"); go("n"); go("-");
    chk("win_steps", int'(step_count), 6);

    // no sword: dead, then buttons ignored
    cyc(1, 0, 0, 0, 0);
    go("e"); go("e"); go("e"); go("s"); go("s"); go("s");
    chk("dragon_nosword", int'(dragon), 1);
    go("-");
    chk("dead_nosword", int'(dead), 1);
    go("n"); go("w"); go("w");

    // reset while the dragon pulse is up
    cyc(1, 0, 0, 0, 0);
    go("e"); go("e"); go("e"); go("s"); go("s"); go("s");
    cyc(1, 1, 0, 0, 0);
    chk("reset_in_dragon_win", int'(win), 0);
    chk("reset_in_dragon_dead", int'(dead), 0);

    // bounce along row 0 long enough to saturate the step counter
    for (int i = 0; i < 140; i++) begin
      go("e"); go("w");
    end

    // random walk with occasional resets
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int mode;
      bit rst;
      logic [3:0] b;
      rst = ($urandom_range(0, 99) < 3);
      mode = $urandom_range(0, 9);
      if (mode < 7) b = 4'b0001 << $urandom_range(0, 3);
      else if (mode == 7) b = 4'b0000;
      else b = 4'($urandom_range(0, 15));
      cyc(rst, b[3], b[2], b[1], b[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
